// File: rtl/typed_chan_arbiter.sv
// Merges NCH per-channel FIFOs onto one registered, channel-tagged output stream.
// Latency: 2 edges from input handshake to out_valid; out_* hold while !out_ready; in_ready low when a FIFO is full.
module typed_chan_arbiter #(
  parameter int W        = 8,
  parameter int NCH      = 4,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NCH-1:0]                   in_valid,
  output logic [NCH-1:0]                   in_ready,
  input  logic [NCH*W-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [W-1:0]                     out_data,
  output logic [$clog2(NCH)-1:0]           out_chan,
  output logic [NCH*($clog2(DEPTH)+1)-1:0] fifo_cnt
);
  localparam int CHW = $clog2(NCH);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  typedef logic [W-1:0] payload_t;
  typedef struct packed {
    logic [CHW-1:0] chan;
    payload_t       data;
  } out_rec_t;
  typedef enum logic {IDLE, SEND} state_t;

  payload_t       head_dat [NCH];
  logic [NCH-1:0] not_empty;
  logic [NCH-1:0] pop_vec;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    payload_t mem_q [DEPTH];
    ptr_t     wr_ptr_q, wr_ptr_d;
    ptr_t     rd_ptr_q, rd_ptr_d;
    cnt_t     cnt_q, cnt_d;
    logic     push;
    logic     pop;

    // Ready looks only at the registered count: a full FIFO never takes a word, even while popping.
    assign in_ready[c]            = (cnt_q != cnt_t'(DEPTH));
    assign push                   = in_valid[c] & in_ready[c];
    assign pop                    = pop_vec[c];
    assign not_empty[c]           = (cnt_q != '0);
    assign head_dat[c]            = mem_q[rd_ptr_q];
    assign fifo_cnt[c*CW +: CW]   = cnt_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + cnt_t'(1);
        2'b01:   cnt_d = cnt_q - cnt_t'(1);
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data[c*W +: W];
    end
  end

  logic [CHW-1:0] rr_q, rr_d;
  logic [CHW-1:0] grant;
  logic           any;

  // Round-robin: first non-empty channel above the last grant, else wrap to the lowest one.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NCH; i++) begin
        if (!any && not_empty[i] && (i > int'(rr_q))) begin
          grant = CHW'(i);
          any   = 1'b1;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!any && not_empty[i]) begin
        grant = CHW'(i);
        any   = 1'b1;
      end
    end
  end

  state_t   state_q, state_d;
  out_rec_t out_q, out_d;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rr_d    = rr_q;
    pop_vec = '0;
    if ((state_q == IDLE) || out_ready) begin
      if (any) begin
        pop_vec[grant] = 1'b1;
        out_d          = '{chan: grant, data: head_dat[grant]};
        rr_d           = grant;
        state_d        = SEND;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      rr_q    <= CHW'(NCH - 1);
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rr_q    <= rr_d;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = out_q.data;
  assign out_chan  = out_q.chan;
endmodule

// File: tb/tb_typed_chan_arbiter.sv
// Bench for typed_chan_arbiter: a round-robin and a fixed-priority instance share one stimulus,
// each tracked by a queue-based model plus directed literal expectations.
module tb_typed_chan_arbiter;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic clk;
  logic rst_n;
  logic [NCH-1:0]   in_valid;
  logic [NCH*8-1:0] in_data;
  logic             out_ready;

  logic [1:0]           ov;
  logic [1:0][NCH-1:0]  ir;
  logic [1:0][7:0]      od;
  logic [1:0][1:0]      oc;
  logic [1:0][NCH*CW-1:0] fc;

  typed_chan_arbiter #(.W(8), .NCH(NCH), .DEPTH(DEPTH), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_chan(oc[0]), .fifo_cnt(fc[0])
  );
  typed_chan_arbiter #(.W(8), .NCH(NCH), .DEPTH(DEPTH), .ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_chan(oc[1]), .fifo_cnt(fc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(string nm, int m, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst=%0d actual=%0h expected=%0h t=%0t", nm, m, act, exp, $time);
  endtask

  // Model: one queue per channel plus the output register, per instance (0 = RR, 1 = fixed).
  logic [7:0] mq [2][NCH][$];
  bit         mv [2];
  logic [7:0] md [2];
  int         mc [2];
  int         mlast [2];
  bit         mdl_rdy [NCH];
  int         mdl_g;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) mq[m][c].delete();
      mv[m]    = 1'b0;
      md[m]    = 8'h00;
      mc[m]    = 0;
      mlast[m] = NCH - 1;
    end
  endtask

  function automatic int pick(int m);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m == 0) ? (mlast[m] + 1 + k) % NCH : k;
      if (mq[m][c].size() != 0) return c;
    end
    return -1;
  endfunction

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < NCH; c++) mdl_rdy[c] = (mq[m][c].size() < DEPTH);
        mdl_g = pick(m);
        if (!mv[m] || out_ready) begin
          if (mdl_g >= 0) begin
            md[m]    = mq[m][mdl_g].pop_front();
            mc[m]    = mdl_g;
            mv[m]    = 1'b1;
            mlast[m] = mdl_g;
          end else begin
            mv[m] = 1'b0;
          end
        end
        for (int c = 0; c < NCH; c++)
          if (in_valid[c] && mdl_rdy[c]) mq[m][c].push_back(in_data[c*8 +: 8]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk("mdl_out_valid", m, 32'(ov[m]), 32'(mv[m]));
        if (mv[m]) begin
          chk("mdl_out_data", m, 32'(od[m]), 32'(md[m]));
          chk("mdl_out_chan", m, 32'(oc[m]), 32'(mc[m]));
        end
        for (int c = 0; c < NCH; c++) begin
          chk("mdl_fifo_cnt", m, 32'(fc[m][c*CW +: CW]), 32'(mq[m][c].size()));
          chk("mdl_in_ready", m, 32'(ir[m][c]), 32'(mq[m][c].size() != DEPTH));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int c, logic [7:0] d);
    in_valid = 4'b0001 << c;
    in_data  = {24'h0, d} << (8 * c);
    step();
    in_valid = '0;
  endtask

  task automatic chk_out(string nm, logic v, logic [7:0] d, logic [1:0] ch);
    for (int m = 0; m < 2; m++) begin
      chk({nm, "_valid"}, m, 32'(ov[m]), 32'(v));
      if (v) begin
        chk({nm, "_data"}, m, 32'(od[m]), 32'(d));
        chk({nm, "_chan"}, m, 32'(oc[m]), 32'(ch));
      end
    end
  endtask

  logic [7:0] rr_dat [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
  logic [1:0] rr_ch  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] fp_dat [8] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31};
  logic [1:0] fp_ch  [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

  initial begin
    rst_n     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_valid", m, 32'(ov[m]), 32'h0);
      chk("rst_out_data",  m, 32'(od[m]), 32'h0);
      chk("rst_out_chan",  m, 32'(oc[m]), 32'h0);
      chk("rst_fifo_cnt",  m, 32'(fc[m]), 32'h0);
      chk("rst_in_ready",  m, 32'(ir[m]), 32'hF);
    end
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // Single word on ch2: visible two edges after the handshake, then back to idle.
    push(2, 8'h11);
    for (int m = 0; m < 2; m++) begin
      chk("lat_edge1_valid", m, 32'(ov[m]), 32'h0);
      chk("lat_edge1_cnt2",  m, 32'(fc[m][2*CW +: CW]), 32'd1);
    end
    step();
    chk_out("lat_edge2", 1'b1, 8'h11, 2'd2);
    step();
    chk_out("lat_idle", 1'b0, 8'h00, 2'd0);

    // Output held with a ch1 word; ch0 filled to DEPTH behind it.
    out_ready = 1'b0;
    push(1, 8'h5A);
    for (int k = 0; k < 4; k++) push(0, 8'hA0 + 8'(k));
    for (int m = 0; m < 2; m++) begin
      chk("full_cnt0",  m, 32'(fc[m][0 +: CW]), 32'd4);
      chk("full_rdy0",  m, 32'(ir[m][0]), 32'h0);
    end
    push(0, 8'hEE);
    for (int m = 0; m < 2; m++) chk("full_5th_cnt0", m, 32'(fc[m][0 +: CW]), 32'd4);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out("hold", 1'b1, 8'h5A, 2'd1);
      for (int m = 0; m < 2; m++) chk("hold_cnt0", m, 32'(fc[m][0 +: CW]), 32'd4);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_out("drain_a", 1'b1, 8'hA0 + 8'(k), 2'd0);
    end
    step();
    chk_out("drain_idle", 1'b0, 8'h00, 2'd0);

    // Reset asserted mid-SEND with non-empty FIFOs.
    out_ready = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'h33221100;
    step();
    step();
    in_valid = '0;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async_rst_valid", m, 32'(ov[m]), 32'h0);
      chk("async_rst_cnt",   m, 32'(fc[m]), 32'h0);
    end
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push(3, 8'h77);
    step();
    chk_out("post_rst_ch3", 1'b1, 8'h77, 2'd3);
    step();

    // Two words per channel, loaded together; RR interleaves, fixed priority drains in index order.
    in_valid = 4'hF;
    in_data  = 32'h30201000;
    step();
    in_data  = 32'h31211101;
    step();
    in_valid = '0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("rr_valid", 0, 32'(ov[0]), 32'h1);
      chk("rr_chan",  0, 32'(oc[0]), 32'(rr_ch[i]));
      chk("rr_data",  0, 32'(od[0]), 32'(rr_dat[i]));
      chk("fp_valid", 1, 32'(ov[1]), 32'h1);
      chk("fp_chan",  1, 32'(oc[1]), 32'(fp_ch[i]));
      chk("fp_data",  1, 32'(od[1]), 32'(fp_dat[i]));
    end
    step();
    chk_out("seq_idle", 1'b0, 8'h00, 2'd0);

    // Random traffic checked by the model, then a bounded drain.
    for (int k = 0; k < 300; k++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (40) step();
    for (int m = 0; m < 2; m++) begin
      chk("drain_end_valid", m, 32'(ov[m]), 32'h0);
      chk("drain_end_cnt",   m, 32'(fc[m]), 32'h0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
